// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit RISC core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, runs memory handshakes with a wait timeout, and latches faults.
module multicycle_control_fsm #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                dmem_req,
  input  logic                dmem_ack,
  output logic                ir_wr,
  output logic                pc_wr,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                reg_wr,
  output logic                link_wr,
  output logic                cmp,
  output logic                mov,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_to_reg,
  output logic                fault,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {K_ALU, K_NOP, K_JMP, K_JAL, K_LW, K_SW} kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [2:0] alu;
    logic       alu_src;
    logic       reg_dst;
    logic       cmp;
    logic       mov;
  } ctrl_t;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            r_state;
  ctrl_t             r_ctrl;
  logic [CNT_W-1:0]  r_wait;

  state_t            w_next;
  ctrl_t             w_dec;
  logic              w_illegal;
  logic              w_waiting;
  logic              w_timeout;
  logic [CNT_W-1:0]  w_wait_next;

  assign w_illegal = (opcode >> 4) != '0;

  always_comb begin
    w_dec = '{kind: K_ALU, alu: 3'b111, alu_src: 1'b0, reg_dst: 1'b0, cmp: 1'b0, mov: 1'b0};
    case (opcode[3:0])
      4'h0: w_dec.kind = K_NOP;
      4'h1: begin w_dec.alu = 3'b000; w_dec.reg_dst = 1'b1; end
      4'h2: begin w_dec.alu = 3'b000; w_dec.alu_src = 1'b1; end
      4'h3: w_dec.alu = 3'b001;
      4'h4: w_dec.alu = 3'b010;
      4'h5: w_dec.alu = 3'b011;
      4'h6: w_dec.alu = 3'b100;
      4'h7: w_dec.kind = K_JAL;
      4'h8: w_dec.cmp = 1'b1;
      4'h9: w_dec.mov = 1'b1;
      4'hA: w_dec.kind = K_JMP;
      4'hB: begin w_dec.reg_dst = 1'b1; w_dec.alu_src = 1'b1; end
      4'hC: begin w_dec.kind = K_LW; w_dec.alu = 3'b000; w_dec.reg_dst = 1'b1; w_dec.alu_src = 1'b1; end
      4'hD: begin w_dec.kind = K_SW; w_dec.alu = 3'b000; w_dec.alu_src = 1'b1; end
      4'hE: begin w_dec.alu = 3'b001; w_dec.cmp = 1'b1; end
      default: begin w_dec.alu = 3'b001; w_dec.cmp = 1'b1; end
    endcase
  end

  // Wait cycles are counted from entry into FETCH/MEM; the ack wins on the last allowed cycle.
  assign w_waiting   = ((r_state == S_FETCH) && !imem_ack) || ((r_state == S_MEM) && !dmem_ack);
  assign w_timeout   = (MEM_TIMEOUT != 0) && w_waiting && (r_wait == CNT_LAST);
  assign w_wait_next = (w_waiting && !w_timeout && (MEM_TIMEOUT != 0)) ? r_wait + 1'b1 : '0;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      r_state <= S_FETCH;
      r_ctrl  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (r_state == S_DECODE) r_ctrl <= w_dec;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (imem_ack)       w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        if (!stall) begin
          if (w_illegal)                w_next = S_FAULT;
          else if (w_dec.kind == K_NOP) w_next = S_FETCH;
          else                          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          case (r_ctrl.kind)
            K_JMP, K_JAL: w_next = S_FETCH;
            K_LW, K_SW:   w_next = S_MEM;
            default:      w_next = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (dmem_ack)       w_next = (r_ctrl.kind == K_LW) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_WB:    if (!stall) w_next = S_FETCH;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  always_comb begin
    // NOTE: every output is given a default first so no latch can be inferred.
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    alu_op     = '0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    reg_wr     = 1'b0;
    link_wr    = 1'b0;
    cmp        = 1'b0;
    mov        = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    fault      = 1'b0;
    state      = 3'd0;
    if (!rst) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_wr    = imem_ack;
          pc_wr    = imem_ack;
        end
        S_EXEC, S_MEM, S_WB: begin
          alu_op  = ALU_OP_W'(r_ctrl.alu);
          alu_src = r_ctrl.alu_src;
          reg_dst = r_ctrl.reg_dst;
          cmp     = r_ctrl.cmp;
          mov     = r_ctrl.mov;
          if (r_state == S_EXEC) begin
            if (r_ctrl.kind == K_JMP) begin
              pc_src = 2'b01;
              pc_wr  = !stall;
            end else if (r_ctrl.kind == K_JAL) begin
              pc_src  = 2'b10;
              pc_wr   = !stall;
              reg_wr  = !stall;
              link_wr = !stall;
            end
          end else if (r_state == S_MEM) begin
            dmem_req = 1'b1;
            mem_rd   = (r_ctrl.kind == K_LW);
            mem_wr   = (r_ctrl.kind == K_SW);
          end else begin
            reg_wr     = !stall;
            mem_to_reg = (r_ctrl.kind == K_LW);
          end
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a table-driven instruction model.
module tb_multicycle_control_fsm;

  localparam int OW = 5;
  localparam int AW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic          imem_ack = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          imem_req, dmem_req, ir_wr, pc_wr;
  logic [1:0]    pc_src;
  logic [AW-1:0] alu_op;
  logic          alu_src, reg_dst, reg_wr, link_wr, cmp, mov;
  logic          mem_rd, mem_wr, mem_to_reg, fault;
  logic [2:0]    state;

  multicycle_control_fsm #(.OPCODE_W(OW), .ALU_OP_W(AW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src(alu_src), .reg_dst(reg_dst), .reg_wr(reg_wr), .link_wr(link_wr),
    .cmp(cmp), .mov(mov), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          imem_req, dmem_req, ir_wr, pc_wr;
    logic [1:0]    pc_src;
    logic [AW-1:0] alu_op;
    logic          alu_src, reg_dst, reg_wr, link_wr, cmp, mov;
    logic          mem_rd, mem_wr, mem_to_reg, fault;
    logic [2:0]    state;
  } outs_t;

  outs_t act;
  assign act = {imem_req, dmem_req, ir_wr, pc_wr, pc_src, alu_op, alu_src, reg_dst, reg_wr,
                link_wr, cmp, mov, mem_rd, mem_wr, mem_to_reg, fault, state};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
  endtask

  // Instruction properties indexed by opcode 0..15.
  int       alu_tab [16] = '{7, 0, 0, 1, 2, 3, 4, 7, 7, 7, 7, 7, 0, 0, 1, 1};
  bit [15:0] src_mask = 16'h3804;
  bit [15:0] dst_mask = 16'h1802;
  bit [15:0] cmp_mask = 16'hC100;
  bit [15:0] mov_mask = 16'h0200;

  // Phase numbers follow the visible state code: 0 F, 1 D, 2 E, 3 M, 4 WB, 7 FAULT.
  int m_phase = 0;
  int m_wait  = 0;
  int m_op    = 0;

  always @(negedge clk) begin
    outs_t e;
    int    nxt;
    e   = '0;
    nxt = m_phase;
    if (rst) begin
      nxt    = 0;
      m_wait = 0;
    end else begin
      e.state = 3'(m_phase);
      if (m_phase >= 2 && m_phase <= 4) begin
        e.alu_op  = AW'(alu_tab[m_op]);
        e.alu_src = src_mask[m_op];
        e.reg_dst = dst_mask[m_op];
        e.cmp     = cmp_mask[m_op];
        e.mov     = mov_mask[m_op];
      end
      case (m_phase)
        0: begin
          e.imem_req = 1'b1;
          if (imem_ack) begin
            e.ir_wr = 1'b1; e.pc_wr = 1'b1; nxt = 1;
          end else if (m_wait + 1 == TO) nxt = 7;
        end
        1: begin
          m_op = int'(opcode);
          if (!stall) nxt = (m_op > 15) ? 7 : (m_op == 0) ? 0 : 2;
        end
        2: begin
          if (m_op == 10) begin
            e.pc_src = 2'b01; e.pc_wr = !stall;
          end else if (m_op == 7) begin
            e.pc_src = 2'b10; e.pc_wr = !stall; e.reg_wr = !stall; e.link_wr = !stall;
          end
          if (!stall) nxt = (m_op == 10 || m_op == 7) ? 0 : (m_op == 12 || m_op == 13) ? 3 : 4;
        end
        3: begin
          e.dmem_req = 1'b1;
          e.mem_rd   = (m_op == 12);
          e.mem_wr   = (m_op == 13);
          if (dmem_ack) nxt = (m_op == 12) ? 4 : 0;
          else if (m_wait + 1 == TO) nxt = 7;
        end
        4: begin
          e.reg_wr     = !stall;
          e.mem_to_reg = (m_op == 12);
          if (!stall) nxt = 0;
        end
        default: e.fault = 1'b1;
      endcase
      m_wait = (nxt == m_phase && (m_phase == 0 || m_phase == 3)) ? m_wait + 1 : 0;
    end
    check("model_cycle", 64'(act), 64'(e));
    m_phase = nxt;
  end

  // Drives one cycle's inputs just after the rising edge and returns at the falling edge.
  task automatic cyc(input logic r, input int op, input logic ia, input logic da, input logic st);
    @(posedge clk);
    #1;
    rst = r; opcode = OW'(op); imem_ack = ia; dmem_ack = da; stall = st;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    check("reset_all_zero", 64'(act), 64'(0));

    // ADD: F(ack) D E WB
    cyc(0, 1, 1, 0, 0);
    check("add_f_state", 64'(state), 64'(0));
    check("add_f_strobes", 64'({imem_req, ir_wr, pc_wr, pc_src}), 64'(5'b11100));
    cyc(0, 1, 0, 0, 0); check("add_d_state", 64'(state), 64'(1));
    cyc(0, 1, 0, 0, 0);
    check("add_e_state", 64'(state), 64'(2));
    check("add_e_regwr", 64'({reg_wr, reg_dst, alu_op}), 64'(6'b010000));
    cyc(0, 1, 0, 0, 0);
    check("add_wb_state", 64'(state), 64'(4));
    check("add_wb_regwr", 64'({reg_wr, reg_dst, alu_op}), 64'(6'b110000));

    // LW with dmem_ack in the 3rd MEM cycle
    cyc(0, 12, 1, 0, 0); check("lw_f_state", 64'(state), 64'(0));
    cyc(0, 12, 0, 0, 0);
    cyc(0, 12, 0, 0, 0); check("lw_e_alusrc", 64'({state, alu_src}), 64'(4'b0101));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 12, 0, (i == 2), 0);
      check("lw_mem_req", 64'({state, dmem_req, mem_rd}), 64'(5'b01111));
    end
    cyc(0, 12, 0, 0, 0);
    check("lw_wb", 64'({state, reg_wr, mem_to_reg}), 64'(5'b10011));

    // JAL
    cyc(0, 7, 1, 0, 0);
    cyc(0, 7, 0, 0, 0);
    cyc(0, 7, 0, 0, 0);
    check("jal_e", 64'({state, pc_wr, pc_src, reg_wr, link_wr}), 64'(8'b010_1_10_1_1));

    // MUL stalled 2 cycles in WB
    cyc(0, 3, 1, 0, 0); check("jal_next_fetch", 64'(state), 64'(0));
    cyc(0, 3, 0, 0, 0);
    cyc(0, 3, 0, 0, 0); check("mul_e_aluop", 64'(alu_op), 64'(1));
    cyc(0, 3, 0, 0, 1); check("stall_wb1", 64'({state, reg_wr}), 64'(4'b1000));
    cyc(0, 3, 0, 0, 1); check("stall_wb2", 64'({state, reg_wr}), 64'(4'b1000));
    cyc(0, 3, 0, 0, 0); check("stall_wb_release", 64'({state, reg_wr}), 64'(4'b1001));

    // SW aborted by rst in MEM
    cyc(0, 13, 1, 0, 0);
    cyc(0, 13, 0, 0, 0);
    cyc(0, 13, 0, 0, 0);
    cyc(0, 13, 0, 0, 0); check("sw_mem", 64'({state, dmem_req, mem_wr}), 64'(5'b01111));
    cyc(1, 13, 0, 0, 0); check("rst_mid_mem", 64'(act), 64'(0));
    cyc(0, 13, 0, 0, 0); check("after_rst_fetch", 64'({state, imem_req}), 64'(4'b0001));

    // Fetch timeout: 4 cycles without ack, then FAULT held until rst
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    check("to_fetch4", 64'(state), 64'(0));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("to_fault", 64'({state, fault, imem_req}), 64'(5'b11110));
    end
    cyc(1, 0, 0, 0, 0);

    // Ack in the 4th FETCH cycle, then illegal opcode 0x13
    for (int i = 0; i < 4; i++) cyc(0, 19, (i == 3), 0, 0);
    check("ack_last_cycle", 64'(ir_wr), 64'(1));
    cyc(0, 19, 0, 0, 0); check("illegal_decode", 64'(state), 64'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 19, 0, 0, 0);
      check("illegal_fault", 64'({state, fault}), 64'(4'b1111));
    end
    cyc(1, 0, 0, 0, 0);

    // NOP: F D F
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); check("nop_back_fetch", 64'(state), 64'(0));

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst      = ($urandom_range(0, 99) < 3);
      imem_ack = ($urandom_range(0, 99) < 60);
      dmem_ack = ($urandom_range(0, 99) < 60);
      stall    = ($urandom_range(0, 99) < 25);
      if (m_phase == 0)
        opcode = ($urandom_range(0, 15) == 0) ? OW'($urandom_range(16, 31)) : OW'($urandom_range(0, 15));
    end
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
